// File: rtl/sha256_pkg.sv
// Shared types and framing constants for the SHA-256 block sequencer.
package sha256_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PAD80,
        S_PADZ,
        S_LEN,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int unsigned BLOCK_BYTES     = 64;
    localparam int unsigned LEN_OFFSET      = 56;
    localparam int unsigned WORDS_PER_BLOCK = 16;
    localparam logic [7:0]  PAD_MARKER      = 8'h80;

endpackage

// File: rtl/sha256_block_buffer.sv
// 16x32 block register file: byte-lane writes (big-endian lanes), word reads.
module sha256_block_buffer
    import sha256_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_clr,
    input  logic        i_we,
    input  logic [5:0]  i_wi,
    input  logic [7:0]  i_data,
    input  logic [3:0]  i_k,
    output logic [31:0] o_word
);

    logic [31:0] r_mem [WORDS_PER_BLOCK];
    logic [1:0]  w_lane;

    // Byte 0 of each word lands in bits [31:24].
    assign w_lane = 2'd3 - i_wi[1:0];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_mem <= '{default: '0};
        end else if (i_we) begin
            r_mem[i_wi[5:2]][{w_lane, 3'b000} +: 8] <= i_data;
        end
    end

    assign o_word = r_mem[i_k];

endmodule

// File: rtl/sha256_block_sequencer.sv
// Frames a byte stream into padded 64-byte SHA-256 blocks and issues them
// to the compression core word by word, one block per core handshake.
module sha256_block_sequencer
    import sha256_pkg::*;
#(
    parameter int unsigned MAX_MSG_BYTES = 65535,
    parameter int unsigned CNT_W         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        byte_ready,
    output logic        core_word_valid,
    output logic [31:0] core_word,
    output logic        core_block_start,
    output logic        core_first_block,
    output logic        core_last_block,
    input  logic        core_block_done,
    output logic        msg_done,
    output logic        err_overflow
);

    localparam logic [5:0] LAST_WI    = 6'(BLOCK_BYTES - 1);
    localparam logic [5:0] LEN_WI     = 6'(LEN_OFFSET);
    localparam logic [5:0] PRE_LEN_WI = 6'(LEN_OFFSET - 1);
    localparam logic [3:0] LAST_K     = 4'(WORDS_PER_BLOCK - 1);

    state_t             r_state, w_nxt;
    logic [5:0]         r_wi;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_k;
    logic               r_first, r_last, r_pend80, r_pendz, r_tgt64, r_err;

    logic               w_accept, w_ovf, w_we;
    logic [7:0]         w_wdata, w_len_byte;
    logic [63:0]        w_bitlen;
    logic [31:0]        w_rdata;

    assign w_accept   = byte_valid & byte_ready;
    assign w_ovf      = (r_cnt == CNT_W'(MAX_MSG_BYTES));
    assign w_bitlen   = 64'({r_cnt, 3'b000});
    assign w_len_byte = w_bitlen[{3'd7 - r_wi[2:0], 3'b000} +: 8];

    assign err_overflow     = r_err;
    assign core_first_block = r_first & (r_state == S_ISSUE);
    assign core_last_block  = r_last & (r_state == S_ISSUE);

    sha256_block_buffer u_buf (
        .i_clk  (clk),
        .i_clr  (rst),
        .i_we   (w_we),
        .i_wi   (r_wi),
        .i_data (w_wdata),
        .i_k    (r_k),
        .o_word (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt            = r_state;
        byte_ready       = 1'b0;
        w_we             = 1'b0;
        w_wdata          = '0;
        core_word_valid  = 1'b0;
        core_word        = '0;
        core_block_start = 1'b0;
        msg_done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                byte_ready = 1'b1;
                if (w_accept) begin
                    w_we    = 1'b1;
                    w_wdata = byte_data;
                    w_nxt   = byte_last ? S_PAD80 : S_LOAD;
                end
            end
            S_LOAD: begin
                byte_ready = 1'b1;
                if (w_accept) begin
                    w_we    = ~w_ovf;
                    w_wdata = byte_data;
                    if (w_ovf) begin
                        if (byte_last) w_nxt = S_PAD80;
                    end else if (r_wi == LAST_WI) begin
                        w_nxt = S_ISSUE;
                    end else if (byte_last) begin
                        w_nxt = S_PAD80;
                    end
                end
            end
            S_PAD80: begin
                w_we    = 1'b1;
                w_wdata = PAD_MARKER;
                // Marker in the last byte already fills the block; zeros follow in the next one.
                if (r_wi == LAST_WI)         w_nxt = S_ISSUE;
                else if (r_wi == PRE_LEN_WI) w_nxt = S_LEN;
                else                         w_nxt = S_PADZ;
            end
            S_PADZ: begin
                w_we = 1'b1;
                if (r_tgt64 && r_wi == LAST_WI)         w_nxt = S_ISSUE;
                else if (!r_tgt64 && r_wi == PRE_LEN_WI) w_nxt = S_LEN;
            end
            S_LEN: begin
                w_we    = 1'b1;
                w_wdata = w_len_byte;
                if (r_wi == LAST_WI) w_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                core_word_valid  = 1'b1;
                core_word        = w_rdata;
                core_block_start = (r_k == 4'd0);
                if (r_k == LAST_K) w_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (core_block_done) begin
                    if (r_last)        w_nxt = S_DONE;
                    else if (r_pend80) w_nxt = S_PAD80;
                    else if (r_pendz)  w_nxt = S_PADZ;
                    else               w_nxt = S_LOAD;
                end
            end
            S_DONE: begin
                msg_done = 1'b1;
                w_nxt    = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wi     <= '0;
            r_cnt    <= '0;
            r_k      <= '0;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
            r_pend80 <= 1'b0;
            r_pendz  <= 1'b0;
            r_tgt64  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_we) r_wi <= r_wi + 6'd1;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_cnt    <= CNT_W'(1);
                    r_err    <= 1'b0;
                    r_first  <= 1'b1;
                    r_last   <= 1'b0;
                    r_pend80 <= 1'b0;
                    r_pendz  <= 1'b0;
                    r_tgt64  <= 1'b0;
                end
                S_LOAD: if (w_accept) begin
                    if (w_ovf) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_wi == LAST_WI && byte_last) r_pend80 <= 1'b1;
                    end
                end
                S_PAD80: begin
                    r_pend80 <= 1'b0;
                    r_tgt64  <= (r_wi >= LEN_WI) && (r_wi != LAST_WI);
                    if (r_wi == LAST_WI) r_pendz <= 1'b1;
                end
                S_PADZ: if (r_tgt64 && r_wi == LAST_WI) begin
                    r_pendz <= 1'b1;
                    r_tgt64 <= 1'b0;
                end
                S_LEN: if (r_wi == LAST_WI) r_last <= 1'b1;
                S_ISSUE: begin
                    r_k <= r_k + 4'd1;
                    if (r_k == LAST_K) r_first <= 1'b0;
                end
                S_WAIT: if (core_block_done) r_pendz <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Scoreboard bench for sha256_block_sequencer: expected block words are queued
// by the stimulus and popped by an independent monitor.
module tb_sha256_block_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_valid, byte_last, core_block_done;
    logic [7:0]  byte_data;
    logic        byte_ready, core_word_valid, core_block_start;
    logic        core_first_block, core_last_block, msg_done, err_overflow;
    logic [31:0] core_word;

    typedef struct packed {
        logic [31:0] w;
        logic        s;
        logic        f;
        logic        l;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   done_delay = 2;
    logic done_at_edge = 1'b0;
    logic last_was_last = 1'b0;

    always #5 clk = ~clk;

    sha256_block_sequencer #(.MAX_MSG_BYTES(100), .CNT_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .byte_valid       (byte_valid),
        .byte_data        (byte_data),
        .byte_last        (byte_last),
        .byte_ready       (byte_ready),
        .core_word_valid  (core_word_valid),
        .core_word        (core_word),
        .core_block_start (core_block_start),
        .core_first_block (core_first_block),
        .core_last_block  (core_last_block),
        .core_block_done  (core_block_done),
        .msg_done         (msg_done),
        .err_overflow     (err_overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Hand-written block: all words zero except w0, w13, w14, w15.
    task automatic push_sparse(input logic f, input logic l, input logic [31:0] w0,
                               input logic [31:0] w13, input logic [31:0] w14, input logic [31:0] w15);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.w = (i == 0) ? w0 : (i == 13) ? w13 : (i == 14) ? w14 : (i == 15) ? w15 : 32'h0;
            e.s = (i == 0);
            e.f = f;
            e.l = l;
            exp_q.push_back(e);
        end
    endtask

    // Reference padding of the message bytes 0,1,2,...,n-1.
    task automatic expect_model(input int unsigned n);
        logic [7:0]  b[$];
        logic [63:0] bl;
        int unsigned nblk;
        exp_t        e;
        for (int unsigned i = 0; i < n; i++) b.push_back(8'(i));
        b.push_back(8'h80);
        while (b.size() % 64 != 56) b.push_back(8'h00);
        bl = 64'(n) << 3;
        for (int i = 7; i >= 0; i--) b.push_back(bl[8*i +: 8]);
        nblk = b.size() / 64;
        for (int unsigned k = 0; k < nblk; k++) begin
            for (int unsigned j = 0; j < 16; j++) begin
                e.w = {b[64*k+4*j], b[64*k+4*j+1], b[64*k+4*j+2], b[64*k+4*j+3]};
                e.s = (j == 0);
                e.f = (k == 0);
                e.l = (k == nblk - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer.
    task automatic send_byte(input logic [7:0] d, input logic last, output int waited);
        waited = 0;
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = last;
        while (!byte_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 1000) chk("byte_timeout", 64'(waited), 64'd0);
        @(negedge clk);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic send_seq(input int unsigned n, input bit pattern, output int max_wait);
        int w;
        max_wait = 0;
        for (int unsigned i = 0; i < n; i++) begin
            send_byte(pattern ? 8'(i) : 8'h00, (i == n - 1), w);
            if (w > max_wait) max_wait = w;
        end
    endtask

    task automatic send_abc();
        int w;
        send_byte(8'h61, 1'b0, w);
        send_byte(8'h62, 1'b0, w);
        send_byte(8'h63, 1'b1, w);
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (!msg_done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_md_in_time"}, 64'(t < 2000), 64'd1);
        @(negedge clk);
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Core model: done pulse a configurable number of cycles after word 15.
    initial begin
        int c = 0;
        core_block_done = 1'b0;
        forever begin
            @(negedge clk);
            if (core_word_valid) begin
                c = core_block_start ? 1 : c + 1;
                if (c == 16) begin
                    c = 0;
                    repeat (done_delay) @(negedge clk);
                    core_block_done = 1'b1;
                    @(negedge clk);
                    core_block_done = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) done_at_edge <= core_block_done;

    // Monitor: pops one expected word per valid cycle, checks msg_done timing.
    always @(negedge clk) begin
        exp_t e;
        logic exp_md;
        if (!rst) begin
            if (core_word_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(core_word), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", 64'({core_word, core_block_start, core_first_block, core_last_block}),
                        64'(e));
                end
                last_was_last = core_last_block;
            end
            exp_md = done_at_edge && last_was_last;
            if (msg_done || exp_md) chk("msg_done", 64'(msg_done), 64'(exp_md));
        end
    end

    initial begin
        int mw, t;
        rst = 1'b1;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_byte_ready", 64'(byte_ready), 64'd1);
        chk("rst_word_valid", 64'(core_word_valid), 64'd0);
        chk("rst_start", 64'(core_block_start), 64'd0);
        chk("rst_first", 64'(core_first_block), 64'd0);
        chk("rst_last", 64'(core_last_block), 64'd0);
        chk("rst_msg_done", 64'(msg_done), 64'd0);
        chk("rst_err", 64'(err_overflow), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        push_sparse(1'b1, 1'b1, 32'h61626380, 32'h0, 32'h0, 32'h00000018);
        send_abc();
        wait_done("abc");

        push_sparse(1'b1, 1'b1, 32'h0, 32'h00000080, 32'h0, 32'h000001B8);
        send_seq(55, 1'b0, mw);
        wait_done("z55");

        push_sparse(1'b1, 1'b0, 32'h0, 32'h0, 32'h80000000, 32'h0);
        push_sparse(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h000001C0);
        send_seq(56, 1'b0, mw);
        wait_done("z56");

        push_sparse(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        push_sparse(1'b0, 1'b1, 32'h80000000, 32'h0, 32'h0, 32'h00000200);
        send_seq(64, 1'b0, mw);
        wait_done("z64");

        // Byte 64 waits out 16 issue cycles, 20 done-delay cycles and the WAIT exit.
        done_delay = 20;
        expect_model(100);
        send_seq(100, 1'b1, mw);
        chk("bp_wait_cycles", 64'(mw), 64'd36);
        wait_done("bp100");
        chk("bp_no_err", 64'(err_overflow), 64'd0);
        done_delay = 2;

        expect_model(100);
        send_seq(103, 1'b1, mw);
        wait_done("ovf");
        chk("ovf_err_set", 64'(err_overflow), 64'd1);

        push_sparse(1'b1, 1'b1, 32'h61626380, 32'h0, 32'h0, 32'h00000018);
        send_abc();
        wait_done("abc_after_ovf");
        chk("ovf_err_cleared", 64'(err_overflow), 64'd0);

        push_sparse(1'b1, 1'b1, 32'h61626380, 32'h0, 32'h0, 32'h00000018);
        send_abc();
        t = 0;
        while (!core_word_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("issue_in_time", 64'(t < 200), 64'd1);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_word_valid", 64'(core_word_valid), 64'd0);
        chk("midrst_byte_ready", 64'(byte_ready), 64'd1);
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);

        push_sparse(1'b1, 1'b1, 32'h61626380, 32'h0, 32'h0, 32'h00000018);
        send_abc();
        wait_done("abc_after_rst");

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sha256_block_sequencer.md
Name: sha256_block_sequencer

Overview:
- Sits between the UART byte stream and the SHA-256 compression core; replaces plain byte-to-word packing with full message framing.
- Buffers message bytes into 64-byte blocks and applies FIPS 180-4 padding: 0x80 marker, zero fill, 64-bit big-endian bit length.
- Issues each block to the core as 16 big-endian 32-bit words, with first/last-block qualifiers.
- Waits for the core's block-done handshake before accepting the next block, and signals end of message.

Parameters:
- MAX_MSG_BYTES, 65535: largest accepted message in bytes. Bytes beyond this raise err_overflow.
- CNT_W, 16: width of the byte counter; must satisfy 2^CNT_W > MAX_MSG_BYTES.

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  message byte.
- byte_last  in  1  qualifies byte_valid; marks the final byte of the message.
- byte_ready  out  1  sequencer accepts a byte this cycle (transfer = byte_valid & byte_ready).
- core_word_valid  out  1  core_word is valid; one word per cycle, 16 consecutive cycles per block.
- core_word  out  32  block word, big-endian (first byte in [31:24]).
- core_block_start  out  1  pulse coincident with word 0 of each block.
- core_first_block  out  1  held for all 16 words of the first block of a message (core loads the initial H).
- core_last_block  out  1  held for all 16 words of the final block.
- core_block_done  in  1  single-cycle pulse from the core; the block is compressed.
- msg_done  out  1  single-cycle pulse after core_block_done of the last block.
- err_overflow  out  1  sticky; cleared by rst or by the next accepted byte in IDLE.

Behaviour:
- Reset values: all outputs 0 except byte_ready = 1. State = IDLE; byte counter, buffer index and flags cleared.
- Block buffer: 16x32 registers. Write index wi (0..63) selects word wi[5:2] and byte lane 3 - wi[1:0].

States and transitions:
- IDLE: byte_ready = 1. An accepted byte is written at wi = 0 and moves to LOAD. If byte_last is set on that byte, go to PAD80 instead.
- LOAD: byte_ready = 1. Each accepted byte writes at wi, then wi++ and bytecnt++.
  - When wi wraps 63 -> 0 without byte_last: go to ISSUE (non-final block), byte_ready = 0.
  - When wi wraps 63 -> 0 with byte_last: go to ISSUE, then continue to PAD80 after WAIT.
  - byte_last with wi < 63: go to PAD80.
- PAD80: byte_ready = 0. Write 0x80 at wi, one cycle, then wi++.
  - If the new wi <= 56: go to PADZ targeting 56.
  - Otherwise: go to PADZ targeting 64, issue the block, then run PADZ from 0 to 56.
- PADZ: write 0x00 one byte per cycle until the target is reached.
- LEN: 8 cycles writing bitlen = {bytecnt, 3'b000} zero-extended to 64 bits, MSB first, into bytes 56..63. Then go to ISSUE with last = 1.
- ISSUE: 16 cycles, word k on cycle k. core_block_start is asserted on k = 0. core_word_valid = 1 for all 16 cycles. Then go to WAIT.
- WAIT: hold until core_block_done.
  - If the block was last: msg_done the next cycle, then IDLE.
  - Else if padding is pending: resume PADZ.
  - Else: go to LOAD with wi = 0 and byte_ready = 1.
- core_first_block is set at message start and cleared after the first block's ISSUE completes.

Latency and boundary cases:
- Latency from the last data byte to the first word of the final ISSUE: 1 (PAD80) + zero fill + 8 (LEN) cycles.
- Zero-length messages are not supported (no frame without a byte).
- byte_valid while byte_ready = 0: ignored. The source must hold the byte.
- core_block_done outside WAIT: ignored.
- Overflow: an accepted byte when bytecnt == MAX_MSG_BYTES sets err_overflow. The byte and all following bytes are dropped until byte_last, which then pads/finishes normally using the truncated count.
- byte_last arriving in the same cycle the buffer fills (wi = 63): the full block is issued non-final, then the padding block {0x80, zeros, len}.
- rst in any state, including mid-ISSUE or WAIT: return to IDLE in the next cycle. No further words are driven and a partial block is not resumed.

Decomposition:
- Shared package sha256_pkg:
  - state enum;
  - constants BLOCK_BYTES = 64, LEN_OFFSET = 56, PAD_MARKER = 8'h80, WORDS_PER_BLOCK = 16.
- One sub-module, sha256_block_buffer: 16x32 register file with a byte-lane write port (wi, data, we), a word read port (k), and a clear.
- The FSM, counters and padding control live in the top block.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63): one block, first = last = 1. w0 = 0x61626380, w1..w14 = 0, w15 = 0x00000018. msg_done 1 cycle after core_block_done.
- 55 bytes of 0x00: one block. w13 = 0x00000080, w14 = 0, w15 = 0x000001B8.
- 56 bytes of 0x00: two blocks.
  - Block 1: w14 = 0x80000000, w15 = 0, last = 0.
  - Block 2: w0..w14 = 0, w15 = 0x000001C0, first = 0, last = 1.
- 64 bytes of 0x00 (last on byte 63): block 1 all zero and non-final. Block 2: w0 = 0x80000000, w15 = 0x00000200.
- Backpressure: delay core_block_done 20 cycles after block 1 of a 100-byte message. byte_ready stays 0 throughout; held bytes are accepted only after done; digest words are unchanged.
- Assert rst at ISSUE word 7. The next cycle shows IDLE, byte_ready = 1, core_word_valid = 0. A fresh "abc" then yields the same words as scenario 1.
